rate_ctrl: RTL and testbench



---
 rtl/rate_ctrl_if.sv | 33 +++
 rtl/rate_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_rate_ctrl.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/rate_ctrl_if.sv
// -----------------------------------------------------------------------------
// rate_ctrl_if
//   Configuration handshake between host logic and rate_ctrl.
//
//   CfgValid  host -> ctrl  a new divide value is offered
//   CfgDiv    host -> ctrl  divide value (half-period = CfgDiv+1 cycles)
//   CfgReady  ctrl -> host  controller can accept a value this cycle
//   CfgAck    ctrl -> host  one-cycle pulse: accepted value is now in effect
//
//   master: host side, slave: controller side.
// -----------------------------------------------------------------------------
interface rate_ctrl_if #(
    parameter int unsigned DIV_W = 26
);
    logic             CfgValid;
    logic [DIV_W-1:0] CfgDiv;
    logic             CfgReady;
    logic             CfgAck;

    modport master (
        output CfgValid,
        output CfgDiv,
        input  CfgReady,
        input  CfgAck
    );

    modport slave (
        input  CfgValid,
        input  CfgDiv,
        output CfgReady,
        output CfgAck
    );
endinterface

// File: rtl/rate_ctrl.sv
// -----------------------------------------------------------------------------
// rate_ctrl
//   Runtime-configurable toggle clock divider with run/stop sequencing.
//   Divide-value changes and stops only take effect on a full-period boundary
//   (the falling edge of ClkOut), so ClkOut never shows runt or stretched pulses.
//
//   Parameters
//     DIV_W        width of the divide value and internal counter
//     DEFAULT_DIV  divide value after reset (half-period = DEFAULT_DIV+1)
//
//   Ports
//     Clk        system clock
//     Rst        synchronous active-high reset
//     Start      begin generating (sampled only while stopped)
//     Stop       stop at the end of the current full period
//     cfg        configuration handshake (rate_ctrl_if.slave)
//     Tick       one-cycle pulse at every half-period terminal count
//     ClkOut     divided clock, 50% duty
//     Running    high while generating (RUN / UPD_PEND)
//     PeriodCnt  completed full periods, wraps at 16 bits
//                (only when RATE_CTRL_PCNT_EN is defined)
//
//   Optional feature macro: RATE_CTRL_PCNT_EN
// -----------------------------------------------------------------------------
module rate_ctrl #(
    parameter int unsigned DIV_W       = 26,
    parameter int unsigned DEFAULT_DIV = 15000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Start,
    input  logic        Stop,
    rate_ctrl_if.slave  cfg,
    output logic        Tick,
    output logic        ClkOut,
`ifdef RATE_CTRL_PCNT_EN
    output logic        Running,
    output logic [15:0] PeriodCnt
`else
    output logic        Running
`endif
);

    localparam logic [DIV_W-1:0] DefaultDiv = DIV_W'(DEFAULT_DIV);

    typedef enum logic [1:0] {
        STOPPED  = 2'd0,
        RUN      = 2'd1,
        UPD_PEND = 2'd2
    } state_t;

    state_t           state;
    state_t           stateNext;

    logic [DIV_W-1:0] divCnt;
    logic [DIV_W-1:0] divReg;
    logic [DIV_W-1:0] shadow;
    logic             stopPend;
    logic             cfgAckR;

    logic             active;
    logic             tc;
    logic             boundary;
    logic             stopNow;

    assign active   = (state != STOPPED);
    assign tc       = active && (divCnt == divReg);
    // A terminal count while ClkOut is high is the falling edge: end of period.
    assign boundary = tc && ClkOut;
    assign stopNow  = boundary && stopPend;

    assign cfg.CfgReady = (state != UPD_PEND);
    assign cfg.CfgAck   = cfgAckR;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= STOPPED;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        case (state)
            STOPPED: begin
                if (Start && !Stop) begin
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (stopNow) begin
                    stateNext = STOPPED;
                end else if (cfg.CfgValid) begin
                    stateNext = UPD_PEND;
                end
            end
            UPD_PEND: begin
                if (stopNow) begin
                    stateNext = STOPPED;
                end else if (boundary) begin
                    stateNext = RUN;
                end
            end
            default: stateNext = STOPPED;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            divCnt    <= '0;
            divReg    <= DefaultDiv;
            shadow    <= '0;
            stopPend  <= 1'b0;
            cfgAckR   <= 1'b0;
            Tick      <= 1'b0;
            ClkOut    <= 1'b0;
            Running   <= 1'b0;
`ifdef RATE_CTRL_PCNT_EN
            PeriodCnt <= '0;
`endif
        end else begin
            cfgAckR <= 1'b0;
            Running <= (stateNext != STOPPED);

            if (state == STOPPED) begin
                Tick <= 1'b0;
                // Loading divReg on the same edge as Start means the first
                // period already uses the new value.
                if (cfg.CfgValid) begin
                    divReg  <= cfg.CfgDiv;
                    cfgAckR <= 1'b1;
                end
                if (Start && !Stop) begin
                    divCnt    <= '0;
`ifdef RATE_CTRL_PCNT_EN
                    PeriodCnt <= '0;
`endif
                end
            end else begin
                if (tc) begin
                    divCnt <= '0;
                    ClkOut <= ~ClkOut;
                    Tick   <= 1'b1;
                end else begin
                    divCnt <= divCnt + DIV_W'(1);
                    Tick   <= 1'b0;
                end

`ifdef RATE_CTRL_PCNT_EN
                if (boundary) begin
                    PeriodCnt <= PeriodCnt + 16'd1;
                end
`endif

                // A config offered in RUN normally waits in shadow for the next
                // boundary; if that boundary is the stop edge happening right
                // now, it is applied directly so it is not lost.
                if (state == RUN && cfg.CfgValid) begin
                    if (stopNow) begin
                        divReg  <= cfg.CfgDiv;
                        cfgAckR <= 1'b1;
                    end else begin
                        shadow  <= cfg.CfgDiv;
                    end
                end

                if (state == UPD_PEND && boundary) begin
                    divReg  <= shadow;
                    cfgAckR <= 1'b1;
                end

                // A Stop seen on a boundary edge stops at the following one.
                if (stopNow) begin
                    stopPend <= 1'b0;
                end else if (Stop) begin
                    stopPend <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_rate_ctrl.sv
module tb_rate_ctrl;

    localparam int DIV_W = 8;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic Rst;
    logic Start;
    logic Stop;
    logic Tick;
    logic ClkOut;
    logic Running;
`ifdef RATE_CTRL_PCNT_EN
    logic [15:0] PeriodCnt;
`endif

    int checks   = 0;
    int failures = 0;

    rate_ctrl_if #(.DIV_W(DIV_W)) cfg ();

    rate_ctrl #(
        .DIV_W      (DIV_W),
        .DEFAULT_DIV(3)
    ) dut (
        .Clk      (Clk),
        .Rst      (Rst),
        .Start    (Start),
        .Stop     (Stop),
        .cfg      (cfg),
        .Tick     (Tick),
        .ClkOut   (ClkOut),
`ifdef RATE_CTRL_PCNT_EN
        .Running  (Running),
        .PeriodCnt(PeriodCnt)
`else
        .Running  (Running)
`endif
    );

    // Advance past one active edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        Rst = 1'b1; Start = 1'b0; Stop = 1'b0;
        cfg.CfgValid = 1'b0; cfg.CfgDiv = '0;
        step(); step();
        checks++; if (ClkOut !== 1'b0) begin failures++; $display("FAIL reset_clkout got %b exp 0", ClkOut); end
        checks++; if (Tick !== 1'b0) begin failures++; $display("FAIL reset_tick got %b exp 0", Tick); end
        checks++; if (cfg.CfgAck !== 1'b0) begin failures++; $display("FAIL reset_ack got %b exp 0", cfg.CfgAck); end
        checks++; if (Running !== 1'b0) begin failures++; $display("FAIL reset_running got %b exp 0", Running); end
        checks++; if (cfg.CfgReady !== 1'b1) begin failures++; $display("FAIL reset_ready got %b exp 1", cfg.CfgReady); end
`ifdef RATE_CTRL_PCNT_EN
        checks++; if (PeriodCnt !== 16'd0) begin failures++; $display("FAIL reset_pcnt got %0d exp 0", PeriodCnt); end
`endif
        Rst = 1'b0;
    endtask

    // DIV=3: ClkOut rises 4 edges after Start, period 8, Tick every 4.
    task automatic test_run();
        logic expClk, expTick;
        Start = 1'b1;
        step();
        Start = 1'b0;
        checks++; if (Running !== 1'b1) begin failures++; $display("FAIL run_running got %b exp 1", Running); end
        checks++; if (ClkOut !== 1'b0) begin failures++; $display("FAIL run_clk0 got %b exp 0", ClkOut); end
        for (int k = 1; k <= 16; k++) begin
            step();
            expClk  = (((k / 4) % 2) == 1);
            expTick = ((k % 4) == 0);
            checks++; if (ClkOut !== expClk) begin failures++; $display("FAIL run_clkout k=%0d got %b exp %b", k, ClkOut, expClk); end
            checks++; if (Tick !== expTick) begin failures++; $display("FAIL run_tick k=%0d got %b exp %b", k, Tick, expTick); end
        end
    endtask

    // Continues from edge 16 of test_run (ClkOut just fell).
    task automatic test_cfg_update();
        logic [5:0] expClk;
        logic [5:0] expTick;
        expClk  = 6'b100110;
        expTick = 6'b101010;
        for (int i = 0; i < 5; i++) step();
        checks++; if (ClkOut !== 1'b1) begin failures++; $display("FAIL upd_highphase got %b exp 1", ClkOut); end
        cfg.CfgValid = 1'b1; cfg.CfgDiv = 8'd1;
        checks++; if (cfg.CfgReady !== 1'b1) begin failures++; $display("FAIL upd_ready_run got %b exp 1", cfg.CfgReady); end
        step();
        cfg.CfgValid = 1'b0;
        checks++; if (cfg.CfgReady !== 1'b0) begin failures++; $display("FAIL upd_ready_pend got %b exp 0", cfg.CfgReady); end
        checks++; if (cfg.CfgAck !== 1'b0) begin failures++; $display("FAIL upd_ack_early got %b exp 0", cfg.CfgAck); end
        step();
        checks++; if (ClkOut !== 1'b1) begin failures++; $display("FAIL upd_still_high got %b exp 1", ClkOut); end
        checks++; if (cfg.CfgReady !== 1'b0) begin failures++; $display("FAIL upd_ready_hold got %b exp 0", cfg.CfgReady); end
        step();
        checks++; if (ClkOut !== 1'b0) begin failures++; $display("FAIL upd_fall got %b exp 0", ClkOut); end
        checks++; if (cfg.CfgAck !== 1'b1) begin failures++; $display("FAIL upd_ack got %b exp 1", cfg.CfgAck); end
        checks++; if (cfg.CfgReady !== 1'b1) begin failures++; $display("FAIL upd_ready_back got %b exp 1", cfg.CfgReady); end
        for (int i = 0; i < 6; i++) begin
            step();
            checks++; if (ClkOut !== expClk[i]) begin failures++; $display("FAIL upd_newclk i=%0d got %b exp %b", i, ClkOut, expClk[i]); end
            checks++; if (Tick !== expTick[i]) begin failures++; $display("FAIL upd_newtick i=%0d got %b exp %b", i, Tick, expTick[i]); end
        end
        checks++; if (cfg.CfgAck !== 1'b0) begin failures++; $display("FAIL upd_ack_pulse got %b exp 0", cfg.CfgAck); end
    endtask

    // Continues with DIV=1, ClkOut just rose. Go back to DIV=3, then stop.
    task automatic test_stop();
        cfg.CfgValid = 1'b1; cfg.CfgDiv = 8'd3;
        step();
        cfg.CfgValid = 1'b0;
        checks++; if (cfg.CfgAck !== 1'b0) begin failures++; $display("FAIL stop_ack_early got %b exp 0", cfg.CfgAck); end
        step();
        checks++; if (cfg.CfgAck !== 1'b1) begin failures++; $display("FAIL stop_ack3 got %b exp 1", cfg.CfgAck); end
        checks++; if (ClkOut !== 1'b0) begin failures++; $display("FAIL stop_fall3 got %b exp 0", ClkOut); end
        for (int i = 0; i < 4; i++) step();
        checks++; if (ClkOut !== 1'b1) begin failures++; $display("FAIL stop_rise got %b exp 1", ClkOut); end
        step();
        Stop = 1'b1;
        step();
        Stop = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++; if (ClkOut !== 1'b1) begin failures++; $display("FAIL stop_hold_high i=%0d got %b exp 1", i, ClkOut); end
            checks++; if (Running !== 1'b1) begin failures++; $display("FAIL stop_running_hold i=%0d got %b exp 1", i, Running); end
            step();
        end
        checks++; if (ClkOut !== 1'b0) begin failures++; $display("FAIL stop_fall got %b exp 0", ClkOut); end
        checks++; if (Running !== 1'b0) begin failures++; $display("FAIL stop_running got %b exp 0", Running); end
        checks++; if (Tick !== 1'b1) begin failures++; $display("FAIL stop_lasttick got %b exp 1", Tick); end
        for (int i = 0; i < 8; i++) begin
            step();
            checks++; if (Tick !== 1'b0) begin failures++; $display("FAIL stop_notick i=%0d got %b exp 0", i, Tick); end
            checks++; if (ClkOut !== 1'b0) begin failures++; $display("FAIL stop_clklow i=%0d got %b exp 0", i, ClkOut); end
        end
    endtask

    task automatic test_start_stop_same();
        Start = 1'b1; Stop = 1'b1;
        step();
        Start = 1'b0; Stop = 1'b0;
        checks++; if (Running !== 1'b0) begin failures++; $display("FAIL ss_running got %b exp 0", Running); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (ClkOut !== 1'b0) begin failures++; $display("FAIL ss_clk i=%0d got %b exp 0", i, ClkOut); end
            checks++; if (Tick !== 1'b0) begin failures++; $display("FAIL ss_tick i=%0d got %b exp 0", i, Tick); end
            step();
        end
    endtask

    task automatic test_div0();
        logic expClk;
        cfg.CfgValid = 1'b1; cfg.CfgDiv = 8'd0; Start = 1'b1;
        checks++; if (cfg.CfgReady !== 1'b1) begin failures++; $display("FAIL d0_ready got %b exp 1", cfg.CfgReady); end
        step();
        cfg.CfgValid = 1'b0; Start = 1'b0;
        checks++; if (cfg.CfgAck !== 1'b1) begin failures++; $display("FAIL d0_ack got %b exp 1", cfg.CfgAck); end
        checks++; if (Running !== 1'b1) begin failures++; $display("FAIL d0_running got %b exp 1", Running); end
        checks++; if (ClkOut !== 1'b0) begin failures++; $display("FAIL d0_clk0 got %b exp 0", ClkOut); end
        for (int k = 1; k <= 6; k++) begin
            step();
            expClk = ((k % 2) == 1);
            checks++; if (ClkOut !== expClk) begin failures++; $display("FAIL d0_clk k=%0d got %b exp %b", k, ClkOut, expClk); end
            checks++; if (Tick !== 1'b1) begin failures++; $display("FAIL d0_tick k=%0d got %b exp 1", k, Tick); end
        end
    endtask

    // Continues with DIV=0 running, ClkOut low.
    task automatic test_rst_upd();
        logic expClk, expTick;
        cfg.CfgValid = 1'b1; cfg.CfgDiv = 8'd5;
        step();
        cfg.CfgValid = 1'b0;
        checks++; if (cfg.CfgReady !== 1'b0) begin failures++; $display("FAIL ru_pend_ready got %b exp 0", cfg.CfgReady); end
        Rst = 1'b1;
        step();
        checks++; if (ClkOut !== 1'b0) begin failures++; $display("FAIL ru_clk got %b exp 0", ClkOut); end
        checks++; if (Tick !== 1'b0) begin failures++; $display("FAIL ru_tick got %b exp 0", Tick); end
        checks++; if (cfg.CfgAck !== 1'b0) begin failures++; $display("FAIL ru_ack got %b exp 0", cfg.CfgAck); end
        checks++; if (Running !== 1'b0) begin failures++; $display("FAIL ru_running got %b exp 0", Running); end
        checks++; if (cfg.CfgReady !== 1'b1) begin failures++; $display("FAIL ru_ready got %b exp 1", cfg.CfgReady); end
        Rst = 1'b0;
        Start = 1'b1;
        step();
        Start = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            step();
            expClk  = (((k / 4) % 2) == 1);
            expTick = ((k % 4) == 0);
            checks++; if (ClkOut !== expClk) begin failures++; $display("FAIL ru_clkout k=%0d got %b exp %b", k, ClkOut, expClk); end
            checks++; if (Tick !== expTick) begin failures++; $display("FAIL ru_tick k=%0d got %b exp %b", k, Tick, expTick); end
            checks++; if (cfg.CfgAck !== 1'b0) begin failures++; $display("FAIL ru_noack k=%0d got %b exp 0", k, cfg.CfgAck); end
        end
    endtask

    // Continues at edge 16 after restart with DIV=3 (two periods completed).
    task automatic test_pcnt();
`ifdef RATE_CTRL_PCNT_EN
        checks++; if (PeriodCnt !== 16'd2) begin failures++; $display("FAIL pc_two got %0d exp 2", PeriodCnt); end
        for (int i = 0; i < 8; i++) step();
        checks++; if (PeriodCnt !== 16'd3) begin failures++; $display("FAIL pc_three got %0d exp 3", PeriodCnt); end
        Stop = 1'b1;
        step();
        Stop = 1'b0;
        for (int i = 0; i < 7; i++) step();
        checks++; if (Running !== 1'b0) begin failures++; $display("FAIL pc_stopped got %b exp 0", Running); end
        checks++; if (PeriodCnt !== 16'd4) begin failures++; $display("FAIL pc_four got %0d exp 4", PeriodCnt); end
        Start = 1'b1;
        step();
        Start = 1'b0;
        checks++; if (PeriodCnt !== 16'd0) begin failures++; $display("FAIL pc_clear got %0d exp 0", PeriodCnt); end
        checks++; if (Running !== 1'b1) begin failures++; $display("FAIL pc_restart got %b exp 1", Running); end
`endif
    endtask

    initial begin
        test_reset();
        test_run();
        test_cfg_update();
        test_stop();
        test_start_stop_same();
        test_div0();
        test_rst_upd();
        test_pcnt();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
